// File: rtl/prime_scan_pkg.sv
// -----------------------------------------------------------------------------
// prime_scan_pkg
//
// Shared definitions for the prime range scanner:
//   state_t    - scanner FSM states (IDLE, SCAN, DONE)
//   value_t    - the 4-bit value type swept by the scanner
//   PRIME_MASK - one bit per 4-bit value, set where that value is prime
//                (2, 3, 5, 7, 11, 13)
//   maskPrime  - helper that looks a value up in PRIME_MASK
// -----------------------------------------------------------------------------
package prime_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] value_t;

    localparam logic [15:0] PRIME_MASK = 16'h28AC;

    // Bit v of the mask is the prime flag for value v.
    function automatic logic maskPrime(input value_t v);
        return PRIME_MASK[v];
    endfunction

endpackage : prime_scan_pkg

// File: rtl/prime_lut.sv
// -----------------------------------------------------------------------------
// prime_lut
//
// Combinational 4-bit prime flag. Behaves exactly like the existing prime
// detector: the input's bit 3 corresponds to the detector's 'a' input and
// bit 0 to its 'd' input.
//
// Ports:
//   value_i  [3:0]  value to classify
//   prime_o         1 when value_i is in {2, 3, 5, 7, 11, 13}
// -----------------------------------------------------------------------------
module prime_lut
    import prime_scan_pkg::*;
(
    input  logic [3:0] value_i,
    output logic       prime_o
);

    always_comb begin
        prime_o = maskPrime(value_t'(value_i));
    end

endmodule : prime_lut

// File: rtl/prime_scan.sv
// -----------------------------------------------------------------------------
// prime_scan
//
// Sequential range scanner feeding the 4-bit prime detector. A start request
// in IDLE captures a [lo, hi] range; the scanner then presents one value per
// cycle (with a valid strobe), tallies how many of them are prime and pulses
// done for one cycle at the end. A range with lo > hi is rejected immediately
// with a done+err pulse and an empty tally.
//
// Optional feature (macro PRIME_SCAN_BOUNDS_EN): adds first_prime_o,
// last_prime_o and prime_found_o, which record the first and last prime
// values encountered during the sweep.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a sweep (only looked at in IDLE)
//   lo_i  [3:0]    first value of the sweep
//   hi_i  [3:0]    last value of the sweep, inclusive
//   busy_o         high while the sweep is running
//   cur_o [3:0]    value currently presented to the detector (bit 3 = a)
//   cur_valid_o    cur_o is a live sweep value this cycle
//   cur_prime_o    prime flag for cur_o, low outside the sweep
//   prime_cnt_o    running/final prime tally, held until the next start
//   done_o         one-cycle end-of-sweep pulse
//   err_o          one-cycle pulse alongside done_o when lo_i > hi_i
//   first_prime_o, last_prime_o, prime_found_o  (PRIME_SCAN_BOUNDS_EN only)
// -----------------------------------------------------------------------------
module prime_scan
    import prime_scan_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       lo_i,
    input  logic [3:0]       hi_i,
    output logic             busy_o,
    output logic [3:0]       cur_o,
    output logic             cur_valid_o,
    output logic             cur_prime_o,
    output logic [CNT_W-1:0] prime_cnt_o,
    output logic             done_o,
    output logic             err_o
`ifdef PRIME_SCAN_BOUNDS_EN
    ,
    output logic [3:0]       first_prime_o,
    output logic [3:0]       last_prime_o,
    output logic             prime_found_o
`endif
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    value_t            cur_q,   cur_d;
    value_t            hi_q,    hi_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              err_q,   err_d;
    logic              lutPrime;
    logic              rangeBad;

`ifdef PRIME_SCAN_BOUNDS_EN
    value_t            first_prime_q, first_prime_d;
    value_t            last_prime_q,  last_prime_d;
    logic              found_q,       found_d;
`endif

    // The single prime lookup always classifies the presented value.
    prime_lut u_prime_lut (
        .value_i (cur_q),
        .prime_o (lutPrime)
    );

    assign rangeBad = (lo_i > hi_i);

    // -------------------------------------------------------------------------
    // State register: all scanner state resets asynchronously to idle/zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cur_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef PRIME_SCAN_BOUNDS_EN
            first_prime_q <= '0;
            last_prime_q  <= '0;
            found_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef PRIME_SCAN_BOUNDS_EN
            first_prime_q <= first_prime_d;
            last_prime_q  <= last_prime_d;
            found_q       <= found_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic.
    // Termination compares cur against the captured hi before incrementing,
    // so a sweep ending at 15 stops there instead of wrapping to 0. The tally
    // picks up the last value's flag on the edge that enters DONE, so the
    // count is already final during the done pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        busy_o      = 1'b0;
        cur_valid_o = 1'b0;
        cur_prime_o = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
`ifdef PRIME_SCAN_BOUNDS_EN
        first_prime_d = first_prime_q;
        last_prime_d  = last_prime_q;
        found_d       = found_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    err_d = rangeBad;
`ifdef PRIME_SCAN_BOUNDS_EN
                    first_prime_d = '0;
                    last_prime_d  = '0;
                    found_d       = 1'b0;
`endif
                    if (rangeBad) begin
                        state_d = DONE;
                    end else begin
                        hi_d    = hi_i;
                        cur_d   = lo_i;
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                busy_o      = 1'b1;
                cur_valid_o = 1'b1;
                cur_prime_o = lutPrime;
                cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, lutPrime};
`ifdef PRIME_SCAN_BOUNDS_EN
                if (lutPrime) begin
                    if (!found_q) begin
                        first_prime_d = cur_q;
                    end
                    last_prime_d = cur_q;
                    found_d      = 1'b1;
                end
`endif
                if (cur_q == hi_q) begin
                    state_d = DONE;
                end else begin
                    cur_d = cur_q + 4'd1;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cur_o       = cur_q;
    assign prime_cnt_o = cnt_q;

`ifdef PRIME_SCAN_BOUNDS_EN
    assign first_prime_o = first_prime_q;
    assign last_prime_o  = last_prime_q;
    assign prime_found_o = found_q;
`endif

endmodule : prime_scan

// File: tb/tb_prime_scan.sv
// -----------------------------------------------------------------------------
// tb_prime_scan
//
// Scoreboard bench for prime_scan. Each sweep request pushes the expected
// stream of presented values followed by one expected done record; a monitor
// on the falling edge pops and compares whenever the scanner shows a valid
// value or a done pulse. The driver separately checks latency and the state
// held after the sweep. Bound outputs are checked when PRIME_SCAN_BOUNDS_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_prime_scan;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       lo = 4'd0;
    logic [3:0]       hi = 4'd0;
    logic             busy;
    logic [3:0]       cur;
    logic             curValid;
    logic             curPrime;
    logic [CNT_W-1:0] primeCnt;
    logic             done;
    logic             err;
`ifdef PRIME_SCAN_BOUNDS_EN
    logic [3:0]       firstPrime;
    logic [3:0]       lastPrime;
    logic             primeFound;
`endif

    typedef struct {
        bit               isDone;
        logic [3:0]       cur;
        logic             prime;
        logic [CNT_W-1:0] cnt;
        logic             err;
        logic [3:0]       first;
        logic [3:0]       last;
        logic             found;
    } expect_t;

    expect_t scoreboard[$];
    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;

    prime_scan #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .start_i      (start),
        .lo_i         (lo),
        .hi_i         (hi),
        .busy_o       (busy),
        .cur_o        (cur),
        .cur_valid_o  (curValid),
        .cur_prime_o  (curPrime),
        .prime_cnt_o  (primeCnt),
        .done_o       (done),
        .err_o        (err)
`ifdef PRIME_SCAN_BOUNDS_EN
        ,
        .first_prime_o(firstPrime),
        .last_prime_o (lastPrime),
        .prime_found_o(primeFound)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference prime set, written out independently of the design's mask.
    function automatic bit modelPrime(input int v);
        return (v == 2) || (v == 3) || (v == 5) || (v == 7) || (v == 11) || (v == 13);
    endfunction

    // Monitor: consume scoreboard entries as the scanner produces output.
    // Reset throws away anything still expected from an aborted sweep.
    always @(negedge clk) begin : monitor
        expect_t e;
        if (!rstN) begin
            scoreboard.delete();
        end else begin
            if (curValid) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(curValid), 32'(0));
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("valid_slot", 32'(e.isDone), 32'(0));
                    checkOutput("cur", 32'(cur), 32'(e.cur));
                    checkOutput("cur_prime", 32'(curPrime), 32'(e.prime));
                    checkOutput("busy_in_scan", 32'(busy), 32'(1));
                end
            end
            if (done) begin
                doneCount++;
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("done_slot", 32'(e.isDone), 32'(1));
                    checkOutput("final_cnt", 32'(primeCnt), 32'(e.cnt));
                    checkOutput("err", 32'(err), 32'(e.err));
                    checkOutput("busy_at_done", 32'(busy), 32'(0));
`ifdef PRIME_SCAN_BOUNDS_EN
                    checkOutput("first_prime", 32'(firstPrime), 32'(e.first));
                    checkOutput("last_prime", 32'(lastPrime), 32'(e.last));
                    checkOutput("prime_found", 32'(primeFound), 32'(e.found));
`endif
                end
            end
        end
    end

    // Request one sweep, queue what it should produce, then wait (bounded)
    // for done and check latency and the idle state that follows. A nonzero
    // pulseAt re-asserts start in that cycle of the sweep, which must be
    // ignored.
    task automatic applyStimulus(input logic [3:0] l, input logic [3:0] h,
                                 input int pulseAt);
        expect_t e;
        int n;
        int cycles;
        int cnt;
        bit found;
        logic [3:0] first;
        logic [3:0] last;

        cnt   = 0;
        found = 1'b0;
        first = 4'd0;
        last  = 4'd0;
        n     = (l <= h) ? (int'(h) - int'(l) + 1) : 0;

        @(negedge clk);
        start = 1'b1;
        lo    = l;
        hi    = h;

        for (int v = int'(l); v <= int'(h); v++) begin
            e        = '{default: '0};
            e.isDone = 1'b0;
            e.cur    = 4'(v);
            e.prime  = modelPrime(v);
            scoreboard.push_back(e);
            if (modelPrime(v)) begin
                cnt++;
                if (!found) first = 4'(v);
                last  = 4'(v);
                found = 1'b1;
            end
        end
        e        = '{default: '0};
        e.isDone = 1'b1;
        e.cnt    = CNT_W'(cnt);
        e.err    = (l > h);
        e.first  = first;
        e.last   = last;
        e.found  = found;
        scoreboard.push_back(e);

        @(negedge clk);
        cycles = 1;
        while (!done && cycles < n + 20) begin
            start = (cycles == pulseAt);
            if (cycles == pulseAt) begin
                lo = 4'd0;
                hi = 4'd1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput("latency", 32'(cycles), 32'(n + 1));

        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'(0));
        checkOutput("idle_done", 32'(done), 32'(0));
        checkOutput("idle_cur_prime", 32'(curPrime), 32'(0));
        checkOutput("held_cnt", 32'(primeCnt), 32'(cnt));
        if (l <= h) begin
            checkOutput("held_cur", 32'(cur), 32'(h));
        end
        checkOutput("drained", 32'(scoreboard.size()), 32'(0));
    endtask

    // Start a full sweep, then drop reset part-way through and confirm the
    // outputs clear at once and no done pulse ever appears.
    task automatic applyResetAbort();
        expect_t e;
        int seenDone;

        @(negedge clk);
        start = 1'b1;
        lo    = 4'd0;
        hi    = 4'd15;
        for (int v = 0; v <= 15; v++) begin
            e        = '{default: '0};
            e.cur    = 4'(v);
            e.prime  = modelPrime(v);
            scoreboard.push_back(e);
        end
        e        = '{default: '0};
        e.isDone = 1'b1;
        e.cnt    = CNT_W'(6);
        scoreboard.push_back(e);

        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        seenDone = doneCount;
        rstN = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'(0));
        checkOutput("abort_valid", 32'(curValid), 32'(0));
        checkOutput("abort_cur", 32'(cur), 32'(0));
        checkOutput("abort_prime", 32'(curPrime), 32'(0));
        checkOutput("abort_cnt", 32'(primeCnt), 32'(0));
        checkOutput("abort_done", 32'(done), 32'(0));
        checkOutput("abort_err", 32'(err), 32'(0));
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount), 32'(seenDone));
        checkOutput("abort_idle", 32'(busy), 32'(0));
        checkOutput("abort_drained", 32'(scoreboard.size()), 32'(0));
    endtask

    initial begin
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_valid", 32'(curValid), 32'(0));
        checkOutput("rst_cur", 32'(cur), 32'(0));
        checkOutput("rst_prime", 32'(curPrime), 32'(0));
        checkOutput("rst_cnt", 32'(primeCnt), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_err", 32'(err), 32'(0));
`ifdef PRIME_SCAN_BOUNDS_EN
        checkOutput("rst_found", 32'(primeFound), 32'(0));
`endif
        rstN = 1'b1;

        applyStimulus(4'd0,  4'd15, 0);
        applyStimulus(4'd7,  4'd7,  0);
        applyStimulus(4'd8,  4'd10, 0);
        applyStimulus(4'd13, 4'd15, 0);
        applyStimulus(4'd9,  4'd3,  0);
        applyStimulus(4'd0,  4'd15, 4);
        applyResetAbort();
        applyStimulus(4'd2,  4'd5,  0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_prime_scan
